word_frame_accumulator: RTL
===========================

Name: word_frame_accumulator

Overview:
- Downstream consumer of the 16-bit arithmetic stage's `output_data` word.
- Captures `FRAME_LEN` words under a valid/ready handshake and accumulates a running sum and a running XOR signature.
- Presents the frame result on a second valid/ready handshake.
- Registers the combinational stage's output and gives the checker/scoreboard one result per frame.

Parameters:
- DATA_W, 16, width of each input word; matches the upstream stage output.
- FRAME_LEN, 8, words per frame; legal range 1..255.
- ACC_W, 24, sum accumulator width; must be >= DATA_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request; honoured only in IDLE.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  upstream word, taken from the arithmetic stage's `output_data`.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  sum of the frame's words.
- out_xor  out  DATA_W  XOR of the frame's words.
- out_cnt  out  8  number of words accumulated; equals FRAME_LEN when out_valid=1.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE.
  - in_ready, out_valid, busy = 0.
  - out_sum, out_xor, out_cnt = 0.
- Reset mid-frame discards the partial frame; no result is emitted.
- FSM states:
  - IDLE -> ACCUM when start=1. On that edge: sum, xor and cnt clear to 0, and busy=1 from the next cycle.
  - ACCUM:
    - in_ready=1.
    - A transfer occurs when in_valid && in_ready.
    - On each transfer: sum <= sum + zero_ext(in_data), mod 2^ACC_W; xor <= xor ^ in_data; cnt <= cnt + 1.
    - When the transfer makes cnt == FRAME_LEN, go to DONE.
  - DONE:
    - in_ready=0.
    - out_valid=1 on the cycle after the last word is accepted (1-cycle latency).
    - On out_ready=1: go to IDLE, clear out_valid and busy, and hold the result registers until the next start.
- Handshake rules:
  - While out_valid=1 && out_ready=0, out_sum, out_xor and out_cnt are stable.
  - in_ready is a registered function of state only. It never depends on in_valid.
- start in ACCUM or DONE is ignored.
- start and the IDLE state never accept a word in the same cycle, because in_ready=0 in IDLE.
- in_valid gaps in ACCUM stall accumulation with no state change.
- FRAME_LEN=1: the single transfer moves the FSM straight to DONE.
- Arithmetic:
  - Unsigned only.
  - Sum wraps silently at 2^ACC_W in the base build.
  - cnt is 8 bits and never exceeds FRAME_LEN.

Optional Feature:
- Macro: WORD_ACC_SAT_EN.
- Defined:
  - The sum add saturates at 2^ACC_W-1 instead of wrapping.
  - Once saturated, the sum holds that value for the rest of the frame.
- Undefined: modulo wrap as above, with no added logic.

Decomposition:
- Package word_acc_pkg holds:
  - state enum (IDLE, ACCUM, DONE);
  - default constants DATA_W_DEF=16, FRAME_LEN_DEF=8, ACC_W_DEF=24;
  - CNT_W=8.
- One sub-module, acc_add: a combinational ACC_W adder with zero-extended DATA_W operand. The saturating path is selected by WORD_ACC_SAT_EN.
- FSM and registers stay in the top.

Test Plan:
- Basic frame, FRAME_LEN=4: start, then words 0x0001, 0x0002, 0x0003, 0x0004 back-to-back -> out_valid 1 cycle after the 4th, out_sum=0x00000A, out_xor=0x0004, out_cnt=4.
- Wrap, ACC_W=17, FRAME_LEN=4, four words of 0xFFFF:
  - base build -> out_sum=0x1FFFC, out_xor=0x0000;
  - with WORD_ACC_SAT_EN -> out_sum=0x1FFFF.
- Bubbles and backpressure, FRAME_LEN=4:
  - in_valid toggles 1,0,1,0,... -> result identical to the basic frame;
  - hold out_ready=0 for 5 cycles -> out_valid and data stable, in_ready=0, and start is ignored throughout.
- Reset mid-frame: assert rst_n=0 after 2 of 4 words -> all outputs 0 immediately; a new start plus 4 words of 0x0010 -> out_sum=0x000040, out_xor=0x0000.
- FRAME_LEN=1 with word 0xABCD -> out_sum=0x00ABCD, out_xor=0xABCD, out_cnt=1; out_ready=1 returns the FSM to IDLE with busy=0 the next cycle.

Source files
------------

// File: rtl/word_acc_pkg.sv
// Shared types and defaults for the word frame accumulator.
// FSM encoding plus default widths; CNT_W bounds FRAME_LEN to 255.
package word_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DATA_W_DEF    = 16;
    localparam int FRAME_LEN_DEF = 8;
    localparam int ACC_W_DEF     = 24;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/word_frame_accumulator_acc_add.sv
// acc_add: accumulator plus zero-extended word; saturates when WORD_ACC_SAT_EN is defined.
// Latency: combinational (0 cycles).
// Backpressure: none; pure datapath.
module acc_add
    import word_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] word,
    output logic [ACC_W-1:0]  sum
);

`ifdef WORD_ACC_SAT_EN
    logic [ACC_W:0] full_sum;

    // One spare bit catches the carry; once pinned at max, further adds stay pinned.
    assign full_sum = {1'b0, acc} + (ACC_W + 1)'(word);
    assign sum      = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    assign sum = acc + ACC_W'(word);
`endif

endmodule

// File: rtl/word_frame_accumulator.sv
// Collects FRAME_LEN words into a sum and XOR signature; optional saturating sum via WORD_ACC_SAT_EN.
// Latency: result valid the cycle after the last word is accepted.
// Backpressure: in_ready low outside ACCUM; result held stable until out_ready.
module word_frame_accumulator
    import word_acc_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_xor,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              busy
);

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [ACC_W-1:0]   sum_q;
    logic [ACC_W-1:0]   sum_next;
    logic [DATA_W-1:0]  xor_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               xfer;
    logic               last_xfer;

    assign xfer      = in_valid && in_ready_q;
    assign last_xfer = xfer && (cnt_q == CNT_W'(FRAME_LEN - 1));

    acc_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_acc_add (
        .acc  (sum_q),
        .word (in_data),
        .sum  (sum_next)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)     state_d = ACCUM;
            ACCUM:   if (last_xfer) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake flags are registered decodes of the next state, so none depend on in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            xor_q <= '0;
            cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            sum_q <= '0;
            xor_q <= '0;
            cnt_q <= '0;
        end else if (xfer) begin
            sum_q <= sum_next;
            xor_q <= xor_q ^ in_data;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_xor   = xor_q;
    assign out_cnt   = cnt_q;

endmodule
